// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: key codes, sequencer states
// and the default operand width.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [3:0] EQUAL = 4'd10;
  localparam logic [3:0] AC    = 4'd11;
  localparam logic [3:0] PLUS  = 4'd12;
  localparam logic [3:0] MINUS = 4'd13;
  localparam logic [3:0] MULT  = 4'd14;
  localparam logic [3:0] DIV   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDSUB,
    ST_MUL,
    ST_DIV
  } seq_state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// The parent owns the iteration count; *_next expose this step's outcome.
module iter_muldiv
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_next,
  output logic [WIDTH-1:0] aux_next
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_mul;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic               div_mode;

  // Divide keeps the partial remainder in acc's low half, the divisor in
  // mcand's low half and shifts the dividend out of mq as quotient bits enter.
  always_comb begin
    acc_mul = acc + (mq[0] ? mcand : '0);
    shifted = {acc[WIDTH-1:0], mq[WIDTH-1]};
    fits    = shifted >= {1'b0, mcand[WIDTH-1:0]};
    rem_n   = fits ? (shifted[WIDTH-1:0] - mcand[WIDTH-1:0]) : shifted[WIDTH-1:0];
    quo_n   = {mq[WIDTH-2:0], fits};
    if (div_mode) begin
      res_next = quo_n;
      aux_next = rem_n;
    end else begin
      res_next = acc_mul[WIDTH-1:0];
      aux_next = acc_mul[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mq       <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      div_mode <= mode_div;
      acc      <= '0;
      mcand    <= mode_div ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      mq       <= mode_div ? a : b;
    end else if (step) begin
      if (div_mode) begin
        acc <= {{WIDTH{1'b0}}, rem_n};
        mq  <= quo_n;
      end else begin
        acc   <= acc_mul;
        mcand <= mcand << 1;
        mq    <= mq >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Calculator arithmetic sequencer: single-cycle add/sub, iterative multiply
// and divide, with a busy/done handshake and abort from the AC key.
module alu_op_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             execute,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       op_code,
  input  logic             abort,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             flag_ovf,
  output logic             flag_neg,
  output logic             flag_div0,
  output logic             flag_inv
);

  seq_state_t       state, state_next;
  logic             execute_q;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             inv_q, div0_q;
  logic             capture, step, finish, cancel;
  logic [WIDTH-1:0] fin_result, fin_rem;
  logic             fin_ovf, fin_neg, fin_div0, fin_inv;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] md_res, md_aux;

  assign start     = execute & ~execute_q;
  assign sum       = {1'b0, a_q} + {1'b0, b_q};
  assign diff      = a_q - b_q;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .load     (capture),
    .step     (step),
    .mode_div (op_code == DIV),
    .a        (operand_a),
    .b        (operand_b),
    .res_next (md_res),
    .aux_next (md_aux)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Invalid codes and divide-by-zero finish through the single-cycle path.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    cancel     = 1'b0;
    fin_result = '0;
    fin_rem    = '0;
    fin_ovf    = 1'b0;
    fin_neg    = 1'b0;
    fin_div0   = 1'b0;
    fin_inv    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          capture = 1'b1;
          if (op_code == MULT)                          state_next = ST_MUL;
          else if (op_code == DIV && operand_b != '0)   state_next = ST_DIV;
          else                                          state_next = ST_ADDSUB;
        end
      end
      ST_ADDSUB: begin
        state_next = ST_IDLE;
        if (abort) begin
          cancel = 1'b1;
        end else begin
          finish = 1'b1;
          if (inv_q) begin
            fin_inv = 1'b1;
          end else if (div0_q) begin
            fin_result = '1;
            fin_div0   = 1'b1;
          end else if (op_q == PLUS) begin
            fin_result = sum[WIDTH-1:0];
            fin_ovf    = sum[WIDTH];
          end else begin
            fin_result = diff;
            fin_neg    = b_q > a_q;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (abort) begin
          cancel     = 1'b1;
          state_next = ST_IDLE;
        end else begin
          step       = 1'b1;
          fin_result = md_res;
          if (state == ST_MUL) fin_ovf = |md_aux;
          else                 fin_rem = md_aux;
          if (last_iter) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      execute_q <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      inv_q     <= 1'b0;
      div0_q    <= 1'b0;
      result    <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      flag_ovf  <= 1'b0;
      flag_neg  <= 1'b0;
      flag_div0 <= 1'b0;
      flag_inv  <= 1'b0;
    end else begin
      execute_q <= execute;
      done      <= 1'b0;
      if (capture) begin
        a_q       <= operand_a;
        b_q       <= operand_b;
        op_q      <= op_code;
        inv_q     <= op_code < PLUS;
        div0_q    <= (op_code == DIV) && (operand_b == '0);
        cnt       <= '0;
        busy      <= 1'b1;
        flag_ovf  <= 1'b0;
        flag_neg  <= 1'b0;
        flag_div0 <= 1'b0;
        flag_inv  <= 1'b0;
      end
      if (step)   cnt  <= cnt + CNT_W'(1);
      if (cancel) busy <= 1'b0;
      if (finish) begin
        busy      <= 1'b0;
        done      <= 1'b1;
        result    <= fin_result;
        remainder <= fin_rem;
        flag_ovf  <= fin_ovf;
        flag_neg  <= fin_neg;
        flag_div0 <= fin_div0;
        flag_inv  <= fin_inv;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected completions,
// an independent monitor pops and compares on every done pulse.
module tb_alu_op_sequencer;
  import calc_pkg::*;

  localparam int W = 16;

  logic         clk, reset, execute, abort;
  logic [W-1:0] operand_a, operand_b;
  logic [3:0]   op_code;
  logic [W-1:0] result, remainder;
  logic         busy, done, flag_ovf, flag_neg, flag_div0, flag_inv;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic [3:0]   flags;
    int           lat;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           tests_run = 0;
  int           tests_failed = 0;
  logic [W-1:0] last_res, last_rem;

  alu_op_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .execute   (execute),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .op_code   (op_code),
    .abort     (abort),
    .result    (result),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .flag_ovf  (flag_ovf),
    .flag_neg  (flag_neg),
    .flag_div0 (flag_div0),
    .flag_inv  (flag_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic, flags packed {ovf,neg,div0,inv}.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t  e;
    longint ai, bi, r;
    ai = longint'(a);
    bi = longint'(b);
    e.res = '0; e.rem = '0; e.flags = 4'b0000; e.lat = 1; e.due = 0;
    if (op < PLUS) begin
      e.flags = 4'b0001;
    end else if (op == PLUS) begin
      r = ai + bi;
      e.res = W'(r % 65536);
      e.flags[3] = (r >= 65536);
    end else if (op == MINUS) begin
      r = ai - bi + 65536;
      e.res = W'(r % 65536);
      e.flags[2] = (bi > ai);
    end else if (op == MULT) begin
      r = ai * bi;
      e.res = W'(r % 65536);
      e.flags[3] = (r >= 65536);
      e.lat = W;
    end else if (bi == 0) begin
      e.res = 16'hFFFF;
      e.flags[1] = 1'b1;
    end else begin
      e.res = W'(ai / bi);
      e.rem = W'(ai % bi);
      e.lat = W;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending completion (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("remainder", remainder, e.rem);
        checkOutput("flags", {flag_ovf, flag_neg, flag_div0, flag_inv}, e.flags);
        checkOutput("latency_cycle", cyc, e.due);
        checkOutput("busy_with_done", busy, 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the start edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                               input bit expect_done, input bit hold);
    exp_t e;
    operand_a = a;
    operand_b = b;
    op_code   = op;
    execute   = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_start", busy, 1);
    if (expect_done) begin
      e = model(a, b, op);
      e.due = cyc + e.lat;
      sb.push_back(e);
      last_res = e.res;
      last_rem = e.rem;
    end
    if (!hold) execute = 1'b0;
    operand_a = W'($urandom);
    operand_b = W'($urandom);
    op_code   = 4'($urandom);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("busy_timeout", busy, 0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_result"}, result, 0);
    checkOutput({name, "_remainder"}, remainder, 0);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_done"}, done, 0);
    checkOutput({name, "_flags"}, {flag_ovf, flag_neg, flag_div0, flag_inv}, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    int           kind;
    reset = 1'b1; execute = 1'b0; abort = 1'b0;
    operand_a = '0; operand_b = '0; op_code = '0;
    last_res = '0; last_rem = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(16'h0012, 16'h0034, PLUS, 1, 0);  waitIdle();
    checkOutput("tp_add", result, 16'h0046);
    applyStimulus(16'h0005, 16'h0007, MINUS, 1, 0); waitIdle();
    checkOutput("tp_sub", result, 16'hFFFE);
    applyStimulus(16'h00FF, 16'h0003, MULT, 1, 0);  waitIdle();
    checkOutput("tp_mul", result, 16'h02FD);
    applyStimulus(16'h0100, 16'h0100, MULT, 1, 0);  waitIdle();
    checkOutput("tp_mul_ovf", flag_ovf, 1);
    applyStimulus(16'h0064, 16'h0007, DIV, 1, 0);   waitIdle();
    checkOutput("tp_div", {result, remainder}, {16'h000E, 16'h0002});
    applyStimulus(16'h0064, 16'h0000, DIV, 1, 0);   waitIdle();
    checkOutput("tp_div0", result, 16'hFFFF);
    applyStimulus(16'h1234, 16'h0042, 4'd4, 1, 0);  waitIdle();
    checkOutput("tp_inv", flag_inv, 1);
    repeat (5) @(negedge clk);
    checkOutput("result_held", result, last_res);

    // Abort a multiply at E5: no completion, outputs held.
    applyStimulus(16'h0033, 16'h0077, MULT, 0, 0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_result", result, last_res);
    checkOutput("abort_remainder", remainder, last_rem);
    checkOutput("abort_flags", {flag_ovf, flag_neg, flag_div0, flag_inv}, 0);
    repeat (20) @(negedge clk);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idle_abort_busy", busy, 0);
    checkOutput("idle_abort_result", result, last_res);

    // Start coincident with abort is dropped.
    operand_a = 16'h0001; operand_b = 16'h0001; op_code = PLUS;
    execute = 1'b1; abort = 1'b1;
    @(negedge clk);
    execute = 1'b0; abort = 1'b0;
    checkOutput("abort_start_busy", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("abort_start_result", result, last_res);

    // Execute held high for 40 cycles yields exactly one completion.
    applyStimulus(16'h0003, 16'h0005, MULT, 1, 1);
    repeat (40) @(negedge clk);
    execute = 1'b0;
    checkOutput("hold_pending", sb.size(), 0);
    checkOutput("hold_result", result, 16'h000F);
    @(negedge clk);

    // Reset in the middle of a divide clears everything at once.
    applyStimulus(16'hFFFF, 16'h0003, DIV, 0, 0);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkAllZero("midreset");
    @(negedge clk);
    reset = 1'b0;
    last_res = '0; last_rem = '0;
    repeat (20) @(negedge clk);
    checkOutput("post_reset_result", result, 0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      ra = W'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 255)) : W'($urandom);
      if (kind == 0)      rop = 4'($urandom_range(0, 11));
      else if (kind == 1) begin rop = DIV; rb = '0; end
      else                rop = 4'(12 + $urandom_range(0, 3));
      applyStimulus(ra, rb, rop, 1, 0);
      if ((rop == MULT || (rop == DIV && rb != '0)) && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        execute = 1'b1;
        @(negedge clk);
        execute = 1'b0;
      end
      waitIdle();
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
